pmem_responder: RTL



---
 rtl/pmem_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pmem_responder.sv
// pmem_responder: line-granular memory stand-in behind the L1 cache.
// One request at a time, fixed latency, one-cycle completion pulse.
module pmem_responder #(
    parameter int LINE_IDX_BITS = 12,
    parameter int LATENCY       = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         protocol_err
);

    localparam int         LINES    = 1 << LINE_IDX_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                   state;
    logic [3:0]               cnt;
    logic                     op_write;
    logic [LINE_IDX_BITS-1:0] idx;
    logic [127:0]             wdata_q;

    logic [127:0] mem [LINES];

    logic                     req;
    logic [LINE_IDX_BITS-1:0] req_idx;
    logic                     enter_resp;
    logic                     commit_write;
    logic [LINE_IDX_BITS-1:0] commit_idx;
    logic [127:0]             commit_data;

    assign req     = pmem_read | pmem_write;
    assign req_idx = LINE_IDX_BITS'(pmem_address >> 4);

    // With LATENCY==1 the commit happens on the accepting edge itself,
    // so the live request fields are used instead of the latched ones.
    always_comb begin
        enter_resp   = 1'b0;
        commit_write = op_write;
        commit_idx   = idx;
        commit_data  = wdata_q;
        unique case (state)
            IDLE: begin
                enter_resp   = req && (LATENCY == 1);
                commit_write = pmem_write;
                commit_idx   = req_idx;
                commit_data  = pmem_wdata;
            end
            BUSY: begin
                enter_resp = (cnt == 4'd1);
            end
            default: begin
                enter_resp = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            op_write     <= 1'b0;
            idx          <= '0;
            wdata_q      <= '0;
            pmem_rdata   <= '0;
            pmem_resp    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            pmem_resp <= 1'b0;
            if (enter_resp && !commit_write) begin
                pmem_rdata <= mem[commit_idx];
            end
            unique case (state)
                IDLE: begin
                    if (req) begin
                        op_write <= pmem_write;
                        idx      <= req_idx;
                        wdata_q  <= pmem_wdata;
                        cnt      <= CNT_LOAD;
                        if (pmem_read && pmem_write) begin
                            protocol_err <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            pmem_resp <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        pmem_resp <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Array has no reset; gating on reset_n drops a commit racing reset.
    always_ff @(posedge clk) begin
        if (reset_n && enter_resp && commit_write) begin
            mem[commit_idx] <= commit_data;
        end
    end

endmodule
